muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: width, default 32, operand/result width in bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only when busy=0.
REQ-005 op  input  3  operation select: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 a  input  width  operand A (dividend / multiplicand / move source), captured when start is accepted.
REQ-007 b  input  width  operand B (divisor / multiplier), captured when start is accepted.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi/lo update from an iterative operation.
REQ-010 hi  output  width  HI register: product upper half or remainder.
REQ-011 lo  output  width  LO register: product lower half or quotient.

Function
REQ-012 The unit SHALL implement states IDLE, RUN and FINISH.
REQ-013 IDLE + start + MULT/MULTU/DIV/DIVU SHALL capture a, b and op, clear the iteration counter and enter RUN next cycle, with busy=1 from that cycle.
REQ-014 IDLE + start + MTHI/MTLO SHALL write a into hi or lo at the same edge, stay in IDLE, and leave busy=0 and done=0.
REQ-015 start while busy=1 SHALL be ignored, with no change to captured operands.
REQ-016 RUN SHALL perform exactly one shift-add (multiply) or one restore-subtract (divide) step per cycle, for exactly width cycles.
REQ-017 After the width-th step the unit SHALL enter FINISH, apply the sign fix-up, write hi/lo, assert done for one cycle, then return to IDLE with busy=0.
REQ-018 Total latency from accepting start to done SHALL be width+2 cycles (34 for width=32); hi/lo SHALL hold their previous values until done.
REQ-019 MULTU SHALL give {hi,lo} = unsigned a*b, modulo 2^(2*width).
REQ-020 MULT SHALL iterate on magnitudes and negate the 2*width product when exactly one operand is negative.
REQ-021 DIVU SHALL give lo = a/b and hi = a%b, unsigned.
REQ-022 DIV SHALL give a quotient truncated toward zero, with the remainder taking the sign of the dividend.
REQ-023 Divide by zero (DIV or DIVU) SHALL give lo = all ones and hi = a (the raw dividend), after the same width+2 latency.
REQ-024 DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0, with no flag or exception.
REQ-025 Operand changes on a/b during RUN SHALL have no effect on the result.
REQ-026 start in the same cycle as done/FINISH SHALL be ignored; the next accepted start is in IDLE.

Reset
REQ-027 reset_n=0 SHALL force, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, and clear internal operand/accumulator registers.
REQ-028 Reset during RUN SHALL abort the operation with no later done pulse; hi/lo SHALL read 0 after reset.
REQ-029 After reset_n deasserts, the first rising edge SHALL be able to accept a start.

Structure
REQ-030 A shared package SHALL hold the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and the state encoding (IDLE, RUN, FINISH).
REQ-031 The per-step add/subtract SHALL instantiate the existing au adder module (parameter width+1, sub input selecting subtract for divide); no other sub-modules.
REQ-032 The state machine, counter, hi/lo, sign fix-up and accumulators SHALL reside in muldiv_unit.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-035 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 MTHI a=0x12345678 -> hi=0x12345678 the next cycle, busy stays 0; a second start issued during a DIVU is ignored and the DIVU result is unaffected.
REQ-038 reset_n pulsed low at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately, no done pulse within the following 40 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [2:0] o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/au.sv
// Plain combinational adder/subtractor shared by the multiply and divide step.
module au #(
  parameter int width = 33
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             sub,
  output logic [width-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo
);

  localparam int CW = $clog2(width) + 1;

  state_e           state, state_nxt;
  op_e              op_r;
  logic [CW-1:0]    cnt;
  logic [width-1:0] acc_hi, acc_lo, mc, a_raw;
  logic             neg_lo, neg_hi;
  logic             accept, signed_op, is_div;
  logic [width-1:0] ma, mb, res_hi, res_lo;
  logic [width:0]   au_a, au_b, au_y;
  logic [2*width-1:0] prod_neg;

  function automatic logic [width-1:0] mag(input logic [width-1:0] v);
    return v[width-1] ? ('0 - v) : v;
  endfunction

  // Start is ignored while busy and in the cycle that carries the done pulse.
  assign accept    = start && (state == IDLE) && !done;
  assign busy      = (state != IDLE);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign ma        = signed_op ? mag(a) : a;
  assign mb        = signed_op ? mag(b) : b;
  assign is_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);

  // Multiply adds the multiplicand into the upper half; divide trial-subtracts from the shifted remainder.
  assign au_a = is_div ? {acc_hi, acc_lo[width-1]} : {1'b0, acc_hi};
  assign au_b = (is_div || acc_lo[0]) ? {1'b0, mc} : '0;

  au #(.width(width + 1)) u_au (
    .a  (au_a),
    .b  (au_b),
    .sub(is_div),
    .y  (au_y)
  );

  assign prod_neg = '0 - {acc_hi, acc_lo};

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      if (mc == '0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        if (neg_lo) res_lo = '0 - acc_lo;
        if (neg_hi) res_hi = '0 - acc_hi;
      end
    end else if (neg_lo) begin
      res_hi = prod_neg[2*width-1:width];
      res_lo = prod_neg[width-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_iter(op)) state_nxt = RUN;
      RUN:     if (cnt == CW'(width - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      op_r   <= MD_MULT;
      acc_hi <= '0;
      acc_lo <= '0;
      mc     <= '0;
      a_raw  <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_r   <= op_e'(op);
                cnt    <= '0;
                a_raw  <= a;
                acc_hi <= '0;
                neg_lo <= signed_op && (a[width-1] ^ b[width-1]);
                neg_hi <= signed_op && a[width-1];
                if ((op == MD_DIV) || (op == MD_DIVU)) begin
                  acc_lo <= ma;
                  mc     <= mb;
                end else begin
                  acc_lo <= mb;
                  mc     <= ma;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (!au_y[width]) begin
              acc_hi <= au_y[width-1:0];
              acc_lo <= {acc_lo[width-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[width-2:0], acc_lo[width-1]};
              acc_lo <= {acc_lo[width-2:0], 1'b0};
            end
          end else begin
            acc_hi <= au_y[width:1];
            acc_lo <= {au_y[0], acc_lo[width-1:1]};
          end
        end
        FINISH: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  muldiv_unit #(.width(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy;
    longint sx, sy, q, r;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULTU: return ux * uy;
      MD_MULT:  return sx * sy;
      MD_DIVU: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        return {r[31:0], q[31:0]};
      end
      MD_DIV: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit disturb, input string tag);
    logic [63:0] r;
    int cyc;
    bit seen;
    r = model(o, x, y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    seen = 0;
    while (!seen && cyc < 40) begin
      if (disturb) begin
        a = $urandom;
        b = $urandom;
        if (cyc == 5) begin start = 1'b1; op = MD_MTHI; end
        else start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
      if (done) seen = 1;
      else if (cyc == 20) chk({tag, " hold_hi_lo"}, {hi, lo}, {exp_hi, exp_lo});
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'd34);
    chk({tag, " result"}, {hi, lo}, r);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    if (disturb) begin start = 1'b1; op = MD_MTLO; a = ~exp_lo; end
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " start_at_done_ignored"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          pulses, cyc;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", {28'h0, busy, done, 2'b00, hi, lo}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    chk("multu_max hi", 64'(hi), 64'hFFFF_FFFE);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,          0, "mult_neg");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,          0, "div_neg");
    run_op(MD_DIVU,  32'd7,         32'd0,          0, "divu_by_zero");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  0, "div_minneg");

    @(negedge clock);
    op = MD_MTHI; a = 32'h1234_5678; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    exp_hi = 32'h1234_5678;
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mthi busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clock);
    op = MD_MTLO; a = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    chk("mtlo hi_lo", {hi, lo}, {exp_hi, exp_lo});

    run_op(MD_DIVU, 32'd1000, 32'd7, 1, "divu_disturbed");

    // Abort a MULT part-way through with an asynchronous reset.
    @(negedge clock);
    op = MD_MULT; a = 32'd12345; b = 32'hFFFF_0000; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi_lo", {hi, lo}, 64'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    chk("abort no_done", 64'(pulses), 64'd0);
    chk("abort hi_lo_after", {hi, lo}, 64'h0);

    // First edge after reset release must accept a start.
    @(negedge clock);
    reset_n = 1'b0;
    op = MD_MULTU; a = 32'd6; b = 32'd9; start = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("post_reset accept", 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("post_reset latency", 64'(cyc), 64'd34);
    chk("post_reset result", {hi, lo}, 64'd54);
    exp_hi = hi === 32'h0 ? 32'h0 : 32'h0;
    exp_lo = 32'd54;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(7))
        0: ry = 32'h0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(15, 1));
        3: rx = 32'($urandom_range(255));
        default: ;
      endcase
      run_op(ro, rx, ry, bit'($urandom_range(1)), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
